// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: three-channel PWM with shadowed duty updates committed at period end.
// Define PWM_INVERT_EN for active-low (LED sink) pwm outputs.
module rgb_pwm_ctrl #(
    parameter int PWM_INTERVAL = 1200,
    localparam int W = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         upd_valid,
    output logic         upd_ready,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    output logic         pwm_r,
    output logic         pwm_g,
    output logic         pwm_b,
    output logic         period_start,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [W-1:0] LAST = W'(PWM_INTERVAL - 1);

    state_t              state, state_n;
    logic [W-1:0]        cnt, cnt_n;
    logic [2:0][W-1:0]   act, sh, duty;
    logic [2:0]          pwm_q;
    logic                ready_q, ps_q;
    logic                xfer, wrap, load, stash, commit, running;

    assign duty = {duty_r, duty_g, duty_b};
    assign xfer = upd_valid && ready_q;
    assign wrap = cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // A transfer landing on the last count goes straight to active, so it never pends.
    always_comb begin
        state_n = !en ? IDLE :
                  state == PEND ? (wrap ? RUN : PEND) :
                  (state == RUN && xfer && !wrap) ? PEND : RUN;
    end

    always_comb begin
        cnt_n   = (state == IDLE || !en || wrap) ? '0 : cnt + 1'b1;
        load    = xfer && state_n != PEND;
        stash   = xfer && state_n == PEND;
        commit  = state == PEND && state_n != PEND;
        running = state != IDLE && state_n != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act     <= '0;
            sh      <= '0;
            pwm_q   <= '0;
            ps_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            ready_q <= state_n != PEND;
            ps_q    <= state_n != IDLE && cnt_n == '0;
            if (load)
                act <= duty;
            else if (commit)
                act <= sh;
            if (stash)
                sh <= duty;
            for (int i = 0; i < 3; i++)
                pwm_q[i] <= running && cnt < act[i];
        end
    end

    assign upd_ready    = ready_q;
    assign period_start = ps_q;
    assign busy         = state == PEND;

`ifdef PWM_INVERT_EN
    assign {pwm_r, pwm_g, pwm_b} = ~pwm_q;
`else
    assign {pwm_r, pwm_g, pwm_b} = pwm_q;
`endif

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 The block SHALL have parameter PWM_INTERVAL, default 1200, meaning PWM period in clk cycles (100 us at 12 MHz); W = ceil(log2(PWM_INTERVAL)).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port en  input  1  run enable; 0 holds the block idle.
REQ-005 The block SHALL have port upd_valid  input  1  requester offers a new duty triple.
REQ-006 The block SHALL have port upd_ready  output  1  block can accept a duty triple this cycle.
REQ-007 The block SHALL have ports duty_r, duty_g, duty_b  input  W each  offered duty values, sampled only on transfer.
REQ-008 The block SHALL have ports pwm_r, pwm_g, pwm_b  output  1 each  registered PWM drive.
REQ-009 The block SHALL have port period_start  output  1  one-cycle pulse on the first cycle of each period.
REQ-010 The block SHALL have port busy  output  1  high while an accepted update awaits commit.

Function
REQ-011 Transfer SHALL occur on a rising clk edge with upd_valid=1 and upd_ready=1; duties captured into a shadow triple.
REQ-012 States SHALL be IDLE (en=0), RUN (en=1, no pending update) and PEND (en=1, shadow awaiting commit).
REQ-013 Period counter cnt SHALL count 0..PWM_INTERVAL-1 and wrap to 0 in RUN/PEND; in IDLE it SHALL hold at 0.
REQ-014 period_start SHALL be 1 in exactly the cycles where en=1 and cnt=0.
REQ-015 IDLE: transfer SHALL load the active triple directly on the same edge; state stays IDLE; upd_ready stays 1.
REQ-016 RUN: transfer with cnt≠PWM_INTERVAL-1 SHALL go to PEND; transfer at cnt=PWM_INTERVAL-1 SHALL load active directly and stay RUN.
REQ-017 PEND: on the edge at cnt=PWM_INTERVAL-1 the active triple SHALL take the shadow and state SHALL return to RUN.
REQ-018 upd_ready SHALL be registered, 1 whenever the next state is not PEND, 0 in PEND.
REQ-019 busy SHALL equal (state==PEND).
REQ-020 en falling in PEND SHALL commit the shadow to active immediately and enter IDLE; no accepted update is ever lost.
REQ-021 In IDLE pwm_x SHALL be 0; en rising SHALL start at cnt=0 with period_start on that first cycle.
REQ-022 In RUN/PEND pwm_x SHALL be registered (cnt < active_x), one cycle latency from cnt.
REQ-023 active_x=0 SHALL give constant 0; active_x ≥ PWM_INTERVAL SHALL saturate to constant 1 for the whole period.
REQ-024 Duty values SHALL be treated as unsigned; no arithmetic wraps.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, cnt 0, active and shadow triples 0, pwm_x 0, period_start 0, busy 0, upd_ready 0.
REQ-026 upd_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-period SHALL discard any pending shadow.

Configuration
REQ-027 With macro PWM_INVERT_EN defined, pwm_r/g/b SHALL be inverted (active-low LED sink): 1 in reset, in IDLE and when off.
REQ-028 Without PWM_INVERT_EN, pwm_r/g/b SHALL be active-high as described in REQ-021 to REQ-025.

Verification
REQ-029 Reset, en=1, transfer (600,0,1199) at cnt=10 -> busy=1, upd_ready=0 until commit at cnt wrap; next period pwm_r high 600 cycles, pwm_g 0, pwm_b high 1199.
REQ-030 Transfer at cnt=1199 in RUN -> no PEND, busy stays 0, new duties take effect in the period starting the next cycle.
REQ-031 duty_r=0 and duty_g=2047 (W=11) -> pwm_r constant 0, pwm_g constant 1 across three full periods.
REQ-032 Transfer (300,300,300) then en=0 at cnt=500 -> IDLE next cycle, outputs 0; on en=1 the period uses 300 with period_start on the first cycle.
REQ-033 Assert rst_n=0 asynchronously in PEND at cnt=700 -> all outputs at reset values immediately, shadow discarded, upd_ready=1 one edge after release.
REQ-034 With PWM_INVERT_EN, repeat REQ-029 -> pwm_r low 600 cycles per period, all pwm_x 1 during reset.
